tag_pool_control: RTL and testbench
===================================

# tag_pool_control

Allocates PSL command tags to outgoing commands and retires them when responses return. It sits between the AFU-control command arbiter, which requests a tag per issued command, and the response path, which frees the tag. It keeps a free-list of valid tags and a per-tag owner table holding the issuing CU ID. The response router uses that CU ID to steer each response back to its compute unit.

## Interface
Parameters:
- TAG_COUNT, 256: tag space size; tag width is $clog2(TAG_COUNT).
- INVALID_TAG, 8'h00: never allocated; freeing it is an error.
- CU_ID_RANGE, 8: width of the CU ID stored per tag.

Ports (reset is asynchronous, active-low):
- clock  in  1  single clock for the whole block.
- rstn  in  1  asynchronous active-low reset.
- enabled_in  in  1  AFU job enabled; low holds the block idle.
- alloc_req  in  1  one tag requested this cycle.
- alloc_cu_id  in  CU_ID_RANGE  owner CU of the requested tag.
- alloc_valid  out  1  grant strobe; alloc_tag is valid.
- alloc_tag  out  8  granted tag.
- free_valid  in  1  response received for free_tag.
- free_tag  in  8  tag being retired.
- free_done  out  1  strobe; free_cu_id is valid.
- free_cu_id  out  CU_ID_RANGE  owner of the retired tag.
- tags_available  out  9  number of tags in the free-list (0..TAG_COUNT-1).
- init_done  out  1  free-list populated; allocation is legal.
- error_double_free  out  1  sticky: a tag was freed while not busy.
- error_invalid_tag  out  1  sticky: INVALID_TAG was freed.

## Operation
State machine:
- **IDLE**: entered from reset. Moves to INIT when enabled_in=1.
- **INIT**: pushes tags 1..TAG_COUNT-1 into the free-list, one per cycle in ascending order. After the last push, moves to READY.
- **READY**: serves alloc_req and free_valid.
- enabled_in=0 in any state returns the machine to IDLE. This clears the free-list, the busy bits, tags_available and init_done. The sticky errors are kept.

Allocation (READY only):
- alloc_req=1 with tags_available>0: pop the FIFO head, set busy[tag]=1, set owner[tag]=alloc_cu_id.
- alloc_req=1 with tags_available=0: no grant. Requests are not queued; the requester re-asserts.
- alloc_req is ignored in IDLE and INIT.

Free (READY only):
- free_valid=1 with a busy, non-INVALID tag: push the tag to the FIFO tail, clear busy[tag], emit owner[tag] on free_cu_id.
- free_valid=1 with busy[tag]=0: no push, no free_done; set error_double_free.
- free_valid=1 with free_tag=INVALID_TAG: ignored; set error_invalid_tag.

Arithmetic and boundaries:
- Simultaneous alloc and free in one cycle: both are performed; tags_available is unchanged.
- The FIFO can never overflow, because pushes are limited to busy tags.
- FIFO pointers are $clog2(TAG_COUNT) bits and wrap modulo TAG_COUNT.

## Timing
- Reset values: all outputs 0, pointers 0, busy table all 0, state IDLE.
- rstn asserted mid-operation clears everything asynchronously. Outstanding tags are abandoned, and INIT reruns after release.
- INIT lasts TAG_COUNT-1 cycles. init_done rises the cycle after the final push, and tags_available reads 255 at the same time.
- Allocation latency: 1 cycle. alloc_req sampled at edge N gives alloc_valid/alloc_tag registered at N+1, asserted for exactly one cycle.
- Free latency: 1 cycle. free_valid at edge N gives free_done/free_cu_id at N+1.
- A freed tag can be allocated by a request sampled at N+1, so it is granted at N+2.
- Back-to-back requests get one grant per cycle.
- tags_available updates in the same cycle as the corresponding alloc_valid or free_done.

## Structure
- GLOBALS_AFU_PKG already holds TAG_COUNT, INVALID_TAG, CU_ID_RANGE and cu_id_t.
- Add to GLOBALS_AFU_PKG:
  - typedef tag_t = logic [0:7];
  - enum tag_pool_state_t {TAG_POOL_IDLE, TAG_POOL_INIT, TAG_POOL_READY}.
- One sub-module, tag_free_fifo: a synchronous ring buffer of depth TAG_COUNT with push/pop, a count output and a flush input.
- The owner table and busy bits live in tag_pool_control.

## Test plan
- Reset, then enabled_in=1 → init_done after 255 cycles, tags_available=255. The first three grants are tags 1, 2, 3 with alloc_cu_id echoed back on free.
- Allocate all 255 tags → tags_available=0. A 256th alloc_req gives no alloc_valid. Free tag 7 (owner 8'h05) → free_cu_id=8'h05; the next request gets tag 7 at N+2.
- Simultaneous alloc_req and free_valid (tag 3) with 10 tags available → grant issued, free_done=1, tags_available stays 10.
- Free tag 9 twice → the second free raises error_double_free with no free_done and no count change. Free tag 0 → error_invalid_tag=1.
- With 40 tags outstanding, pulse rstn low → all outputs 0 immediately. After release and enable, INIT repeats and tags_available returns to 255.
- enabled_in dropped during INIT at tag 100 → state IDLE, tags_available=0. On re-enable, INIT restarts from tag 1.

Source files
------------

// File: rtl/globals_afu_pkg.sv
// rtl/globals_afu_pkg.sv - shared AFU constants and types for the tag pool
//
// Purpose: tag space size, the reserved tag value, CU ID width, the tag and
// CU ID types, and the tag pool state encoding.
package globals_afu_pkg;

  localparam int TAG_COUNT   = 256;
  localparam int CU_ID_RANGE = 8;
  localparam int TAG_W       = $clog2(TAG_COUNT);
  // One extra bit so a full free-list count is representable.
  localparam int CNT_W       = TAG_W + 1;

  typedef logic [0:7] tag_t;
  typedef logic [CU_ID_RANGE-1:0] cu_id_t;

  localparam tag_t INVALID_TAG = 8'h00;

  typedef enum logic [1:0] {
    TAG_POOL_IDLE,
    TAG_POOL_INIT,
    TAG_POOL_READY
  } tag_pool_state_t;

endpackage

// File: rtl/tag_pool_control_if.sv
// rtl/tag_pool_control_if.sv - allocate/free handshake bundle for the tag pool
//
// Purpose: groups the allocation request/grant and the free/retire signals.
// master: command arbiter and response path (drive alloc_req, alloc_cu_id,
//         free_valid, free_tag; receive grant and retire strobes).
// slave : tag_pool_control (drives alloc_valid, alloc_tag, free_done,
//         free_cu_id).
interface tag_pool_control_if;
  import globals_afu_pkg::*;

  logic   alloc_req;
  cu_id_t alloc_cu_id;
  logic   alloc_valid;
  tag_t   alloc_tag;
  logic   free_valid;
  tag_t   free_tag;
  logic   free_done;
  cu_id_t free_cu_id;

  modport master (
    output alloc_req, alloc_cu_id, free_valid, free_tag,
    input  alloc_valid, alloc_tag, free_done, free_cu_id
  );

  modport slave (
    input  alloc_req, alloc_cu_id, free_valid, free_tag,
    output alloc_valid, alloc_tag, free_done, free_cu_id
  );

endinterface

// File: rtl/tag_free_fifo.sv
// rtl/tag_free_fifo.sv - ring buffer holding the free tags
//
// Purpose: synchronous free-list of depth DEPTH with push/pop and flush.
// Ports: clock, rstn (async active-low), flush_i (clear pointers/count),
//        push_i/push_tag_i (write at tail), pop_i (advance head),
//        head_tag_o (tag at head), count_o (entries held).
module tag_free_fifo
  import globals_afu_pkg::*;
#(
  parameter int DEPTH = TAG_COUNT
) (
  input  logic             clock,
  input  logic             rstn,
  input  logic             flush_i,
  input  logic             push_i,
  input  tag_t             push_tag_i,
  input  logic             pop_i,
  output tag_t             head_tag_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int PW = $clog2(DEPTH);

  tag_t             mem_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointers wrap naturally at DEPTH (power of two).
      if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; only entries between the pointers are meaningful.
  always_ff @(posedge clock) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_tag_i;
  end

  assign head_tag_o = mem_q[rd_ptr_q];
  assign count_o    = count_q;

endmodule

// File: rtl/tag_pool_control.sv
// rtl/tag_pool_control.sv - PSL command tag allocator with owner tracking
//
// Purpose: fills a free-list with tags 1..TAG_COUNT-1, grants one tag per
// request, records the issuing CU per tag and returns it when the tag retires.
// Ports: clock, rstn (async active-low), enabled_in (low forces idle/clear),
//        pool_if (slave side of the alloc/free handshake), tags_available,
//        init_done, error_double_free / error_invalid_tag (sticky).
module tag_pool_control
  import globals_afu_pkg::*;
(
  input  logic              clock,
  input  logic              rstn,
  input  logic              enabled_in,
  tag_pool_control_if.slave pool_if,
  output logic [CNT_W-1:0]  tags_available,
  output logic              init_done,
  output logic              error_double_free,
  output logic              error_invalid_tag
);

  localparam tag_t LAST_TAG = tag_t'(TAG_COUNT - 1);

  tag_pool_state_t      state_q, state_d;
  tag_t                 init_tag_q, init_tag_d;
  logic                 init_push;
  logic [TAG_COUNT-1:0] busy_q;
  cu_id_t               owner_q [TAG_COUNT];

  logic   alloc_valid_q, free_done_q, err_dbl_q, err_inv_q;
  tag_t   alloc_tag_q;
  cu_id_t free_cu_id_q;

  tag_t             head_tag;
  logic [CNT_W-1:0] fifo_count;
  logic             serving, alloc_fire, free_fire, free_is_invalid;

  always_comb begin
    state_d    = state_q;
    init_tag_d = init_tag_q;
    init_push  = 1'b0;
    if (!enabled_in) begin
      state_d    = TAG_POOL_IDLE;
      init_tag_d = tag_t'(1);
    end else begin
      case (state_q)
        TAG_POOL_IDLE: begin
          state_d    = TAG_POOL_INIT;
          init_tag_d = tag_t'(1);
        end
        TAG_POOL_INIT: begin
          init_push  = 1'b1;
          init_tag_d = init_tag_q + tag_t'(1);
          if (init_tag_q == LAST_TAG) state_d = TAG_POOL_READY;
        end
        TAG_POOL_READY: state_d = TAG_POOL_READY;
        default:        state_d = TAG_POOL_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      state_q    <= TAG_POOL_IDLE;
      init_tag_q <= tag_t'(1);
    end else begin
      state_q    <= state_d;
      init_tag_q <= init_tag_d;
    end
  end

  assign serving         = enabled_in && (state_q == TAG_POOL_READY);
  assign free_is_invalid = (pool_if.free_tag == INVALID_TAG);
  assign alloc_fire      = serving && pool_if.alloc_req && (fifo_count != '0);
  // The head tag is never busy, so an alloc and a free in the same cycle
  // always touch different busy/owner entries.
  assign free_fire       = serving && pool_if.free_valid && !free_is_invalid
                           && busy_q[pool_if.free_tag];

  tag_free_fifo #(.DEPTH(TAG_COUNT)) u_free_fifo (
    .clock      (clock),
    .rstn       (rstn),
    .flush_i    (!enabled_in),
    .push_i     (init_push || free_fire),
    .push_tag_i (init_push ? init_tag_q : pool_if.free_tag),
    .pop_i      (alloc_fire),
    .head_tag_o (head_tag),
    .count_o    (fifo_count)
  );

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      busy_q        <= '0;
      alloc_valid_q <= 1'b0;
      alloc_tag_q   <= '0;
      free_done_q   <= 1'b0;
      free_cu_id_q  <= '0;
      err_dbl_q     <= 1'b0;
      err_inv_q     <= 1'b0;
    end else begin
      alloc_valid_q <= alloc_fire;
      free_done_q   <= free_fire;
      if (!enabled_in) begin
        busy_q <= '0;
      end else begin
        if (alloc_fire) busy_q[head_tag] <= 1'b1;
        if (free_fire)  busy_q[pool_if.free_tag] <= 1'b0;
      end
      if (alloc_fire) alloc_tag_q  <= head_tag;
      if (free_fire)  free_cu_id_q <= owner_q[pool_if.free_tag];
      if (serving && pool_if.free_valid) begin
        if (free_is_invalid)                   err_inv_q <= 1'b1;
        else if (!busy_q[pool_if.free_tag])    err_dbl_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (alloc_fire) owner_q[head_tag] <= pool_if.alloc_cu_id;
  end

  assign pool_if.alloc_valid = alloc_valid_q;
  assign pool_if.alloc_tag   = alloc_tag_q;
  assign pool_if.free_done   = free_done_q;
  assign pool_if.free_cu_id  = free_cu_id_q;
  assign tags_available      = fifo_count;
  assign init_done           = (state_q == TAG_POOL_READY);
  assign error_double_free   = err_dbl_q;
  assign error_invalid_tag   = err_inv_q;

endmodule

// File: tb/tb_tag_pool_control.sv
// tb/tb_tag_pool_control.sv - directed self-checking bench for tag_pool_control
module tb_tag_pool_control;

  logic       clock = 1'b0;
  logic       rstn;
  logic       enabled_in;
  logic [8:0] tags_available;
  logic       init_done;
  logic       error_double_free;
  logic       error_invalid_tag;

  int n_checks = 0;
  int n_fail   = 0;

  int         q[$];
  logic [7:0] own [256];

  tag_pool_control_if pif ();

  tag_pool_control dut (
    .clock             (clock),
    .rstn              (rstn),
    .enabled_in        (enabled_in),
    .pool_if           (pif),
    .tags_available    (tags_available),
    .init_done         (init_done),
    .error_double_free (error_double_free),
    .error_invalid_tag (error_invalid_tag)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic model_init();
    q.delete();
    for (int i = 1; i < 256; i++) q.push_back(i);
  endtask

  task automatic alloc_one(input logic [7:0] cu);
    int exp_tag;
    exp_tag = q[0];
    pif.alloc_req   = 1'b1;
    pif.alloc_cu_id = cu;
    tick();
    pif.alloc_req = 1'b0;
    check("alloc_valid", pif.alloc_valid, 1);
    check("alloc_tag", pif.alloc_tag, exp_tag);
    own[exp_tag] = cu;
    void'(q.pop_front());
  endtask

  task automatic free_one(input int t);
    pif.free_valid = 1'b1;
    pif.free_tag   = t;
    tick();
    pif.free_valid = 1'b0;
    q.push_back(t);
    check("free_done", pif.free_done, 1);
    check("free_cu_id", pif.free_cu_id, own[t]);
    check("tags_avail_free", tags_available, q.size());
  endtask

  task automatic run_init();
    tick();
    repeat (254) tick();
    check("init_done_early", init_done, 0);
    check("tags_avail_254", tags_available, 254);
    tick();
    check("init_done", init_done, 1);
    check("tags_avail_255", tags_available, 255);
    model_init();
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_alloc_valid"}, pif.alloc_valid, 0);
    check({name, "_free_done"}, pif.free_done, 0);
    check({name, "_tags_avail"}, tags_available, 0);
    check({name, "_init_done"}, init_done, 0);
    check({name, "_err_dbl"}, error_double_free, 0);
    check({name, "_err_inv"}, error_invalid_tag, 0);
  endtask

  initial begin
    int exp_tag;
    logic [7:0] cu;

    rstn            = 1'b0;
    enabled_in      = 1'b0;
    pif.alloc_req   = 1'b0;
    pif.alloc_cu_id = '0;
    pif.free_valid  = 1'b0;
    pif.free_tag    = '0;
    repeat (3) tick();
    check_all_zero("reset");
    rstn       = 1'b1;
    enabled_in = 1'b1;
    run_init();

    // First grants and their owners echoed back on free.
    alloc_one(8'h11);
    check("alloc_strobe_one_cycle", pif.alloc_valid, 1);
    tick();
    check("alloc_strobe_drop", pif.alloc_valid, 0);
    alloc_one(8'h22);
    alloc_one(8'h33);
    check("tags_avail_252", tags_available, 252);
    free_one(2);
    free_one(1);
    free_one(3);

    // Drain the pool with back-to-back requests.
    pif.alloc_req = 1'b1;
    for (int i = 0; i < 255; i++) begin
      exp_tag = q[0];
      cu = (exp_tag == 7) ? 8'h05 : 8'(exp_tag + 1);
      pif.alloc_cu_id = cu;
      tick();
      check("b2b_valid", pif.alloc_valid, 1);
      check("b2b_tag", pif.alloc_tag, exp_tag);
      own[exp_tag] = cu;
      void'(q.pop_front());
    end
    check("tags_avail_empty", tags_available, 0);
    tick();
    pif.alloc_req = 1'b0;
    check("no_grant_when_empty", pif.alloc_valid, 0);
    check("tags_avail_still_0", tags_available, 0);

    free_one(7);
    check("owner_tag7", pif.free_cu_id, 8'h05);
    alloc_one(8'h44);
    check("tags_avail_after_regrant", tags_available, 0);

    // Simultaneous alloc and free with ten tags free.
    for (int t = 20; t < 30; t++) free_one(t);
    check("tags_avail_10", tags_available, 10);
    pif.alloc_req   = 1'b1;
    pif.alloc_cu_id = 8'h77;
    pif.free_valid  = 1'b1;
    pif.free_tag    = 3;
    tick();
    pif.alloc_req  = 1'b0;
    pif.free_valid = 1'b0;
    check("sim_alloc_valid", pif.alloc_valid, 1);
    check("sim_alloc_tag", pif.alloc_tag, 20);
    check("sim_free_done", pif.free_done, 1);
    check("sim_free_cu", pif.free_cu_id, own[3]);
    check("sim_tags_avail", tags_available, 10);
    own[20] = 8'h77;
    void'(q.pop_front());
    q.push_back(3);

    // Double free and invalid tag.
    free_one(9);
    check("err_dbl_clear", error_double_free, 0);
    pif.free_valid = 1'b1;
    pif.free_tag   = 9;
    tick();
    pif.free_valid = 1'b0;
    check("dbl_no_done", pif.free_done, 0);
    check("dbl_err", error_double_free, 1);
    check("dbl_tags_avail", tags_available, 11);
    check("err_inv_clear", error_invalid_tag, 0);
    pif.free_valid = 1'b1;
    pif.free_tag   = 0;
    tick();
    pif.free_valid = 1'b0;
    check("inv_no_done", pif.free_done, 0);
    check("inv_err", error_invalid_tag, 1);
    check("inv_tags_avail", tags_available, 11);

    // Asynchronous reset mid-operation with tags outstanding.
    @(posedge clock);
    #3;
    rstn = 1'b0;
    #1;
    check_all_zero("async_rst");
    tick();
    rstn = 1'b1;
    run_init();
    alloc_one(8'h01);

    // Sticky error survives a disable.
    pif.free_valid = 1'b1;
    pif.free_tag   = 0;
    tick();
    pif.free_valid = 1'b0;
    check("inv_err2", error_invalid_tag, 1);
    enabled_in = 1'b0;
    tick();
    check("dis_tags_avail", tags_available, 0);
    check("dis_init_done", init_done, 0);
    check("dis_err_sticky", error_invalid_tag, 1);

    // Disable in the middle of INIT, then restart from tag 1.
    enabled_in = 1'b1;
    tick();
    repeat (100) tick();
    check("mid_init_tags", tags_available, 100);
    check("mid_init_done", init_done, 0);
    enabled_in = 1'b0;
    tick();
    check("abort_tags", tags_available, 0);
    check("abort_init_done", init_done, 0);
    enabled_in = 1'b1;
    run_init();
    alloc_one(8'h2A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
